pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the opcode control unit.
- Owns the program counter and fetches 32-bit words from a variable-latency instruction memory.
- Holds each fetched instruction in an instruction register and presents instr[31:26] as op_code to decode.
- Computes the next PC from the Jump, Branch and Zero signals returned by decode/execute when the downstream stage signals advance.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request; address valid while high.
- imem_addr  output  32  byte address of the word being fetched; equals pc.
- imem_ready  input  1  memory returns imem_rdata this cycle; may be high in the same cycle as imem_req.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  instruction register.
- instr_valid  output  1  instr is valid and held for decode.
- op_code  output  6  instr[31:26], feeds the control unit.
- pc  output  32  address of instr.
- pc_plus4  output  32  pc + 4 (used for the jal link).
- advance  input  1  downstream has consumed instr; Jump/Branch/Zero are valid this cycle.
- Jump  input  1  from the control unit.
- Branch  input  1  from the control unit.
- Zero  input  1  ALU zero flag.
- retired  output  CNT_W  count of advanced instructions.

Behaviour:
- Reset (asynchronous, immediate on rst high):
  - pc = RESET_PC; state = S_FETCH; instr = 0; instr_valid = 0; retired = 0.
  - imem_req is 0 while rst is high and 1 in the first cycle after release.
- States:
  - S_FETCH: imem_req = 1, imem_addr = pc, instr_valid = 0. When imem_ready = 1: at the edge, instr <= imem_rdata, instr_valid <= 1, go to S_HOLD.
  - S_HOLD: imem_req = 0; instr, pc and instr_valid are held stable. When advance = 1: at the edge, pc <= next_pc, instr_valid <= 0, retired <= retired + 1, go to S_FETCH.
- Next PC, evaluated in the advance cycle only, in priority order:
  1. Jump = 1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  2. Branch = 1 and Zero = 1: pc_plus4 + (sign_extend(instr[15:0]) << 2).
  3. Otherwise: pc_plus4.
  - Jump priority makes don't-care Branch values from jal harmless. jr is not supported.
- Arithmetic:
  - All PC arithmetic is 32-bit modulo 2^32; 0xFFFF_FFFC + 4 wraps to 0.
  - pc[1:0] is always 0.
  - retired wraps to 0 at overflow.
- Latency:
  - Minimum one cycle per fetch: imem_ready high in the first S_FETCH cycle gives instr_valid on the next cycle.
  - Minimum two cycles per instruction.
- Boundary conditions:
  - imem_ready in S_HOLD, or while rst is high: ignored; instr is unchanged.
  - advance in S_FETCH: ignored; pc and retired are unchanged.
  - Jump, Branch and Zero outside the advance cycle: ignored, and may be X.
  - imem_rdata is sampled only on the imem_ready edge in S_FETCH.
  - Reset mid-fetch or mid-hold: the outstanding fetch is abandoned and the next request uses RESET_PC. A late imem_ready for the abandoned fetch, arriving after reset release, is accepted as the RESET_PC word. The memory must not complete a fetch across reset.
- Outputs are driven from registers/state only; there is no combinational path from advance to imem_req in the same cycle.

Decomposition:
- Shared package (mips_pkg):
  - opcode constants OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B, OP_ANDI = 6'h0C, OP_BEQ = 6'h04, OP_JAL = 6'h03;
  - state encoding S_FETCH / S_HOLD;
  - RESET_PC default.
- One natural sub-module, next_pc_calc: a combinational jump/branch/sequential target mux.

Test Plan:
- Reset: rst pulse, RESET_PC = 0 → pc = 0, instr_valid = 0, retired = 0; imem_req = 1 with imem_addr = 0 in the first cycle after release.
- Sequential zero-wait: ready = 1 on each request, word 0x20080005 (addi) at 0, advance with Jump = Branch = 0 → op_code = 6'h08, then pc = 4, retired = 1.
- Branch taken / not taken: pc = 0x10, instr = 0x1000FFFF (beq, imm = -1), Branch = 1:
  - Zero = 1 → next pc = 0x10.
  - Zero = 0 → next pc = 0x14.
- Jump: pc = 0x1000_0008, instr = 0x0C000040 (jal), Jump = 1, Branch = X → next pc = 0x1000_0100; pc_plus4 = 0x1000_000C while held.
- Wait states and hold:
  - ready asserted 3 cycles after req → instr_valid rises on the 4th cycle.
  - Stray ready pulses in S_HOLD leave instr unchanged.
  - advance held low for 5 cycles → outputs stable.
- Reset mid-fetch and wrap:
  - rst during S_FETCH at pc = 0x40 → pc = RESET_PC and a fresh request.
  - pc = 0xFFFF_FFFC, sequential advance → pc = 0x0000_0000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS-subset definitions: opcodes, fetch-stage state encoding and
// the default reset vector.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } fetch_state_e;

  // Branch displacement in bytes: sign-extended word offset shifted left by two.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: jump target, taken branch, or fall-through.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] target_field,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] jump_target;
  logic [31:0] branch_target;

  assign jump_target   = {pc_plus4[31:28], target_field, 2'b00};
  assign branch_target = pc_plus4 + branch_offset(target_field[15:0]);

  // Jump wins so that don't-care branch bits on jal never matter.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches from variable-latency memory,
// holds the word for decode and steps the PC when downstream advances.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [5:0]       op_code,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic             advance,
  input  logic             Jump,
  input  logic             Branch,
  input  logic             Zero,
  output logic [CNT_W-1:0] retired
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             instr_valid_q, instr_valid_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [31:0]      next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  next_pc_calc u_next_pc_calc (
    .pc_plus4     (pc_plus4),
    .target_field (instr_q[25:0]),
    .jump         (Jump),
    .branch       (Branch),
    .zero         (Zero),
    .next_pc      (next_pc)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    retired_d     = retired_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (advance) begin
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          retired_d     = retired_q + CNT_W'(1);
          state_d       = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      retired_q     <= retired_d;
    end
  end

  // The state register sits in S_FETCH during reset, so the request is masked
  // until reset is released.
  assign imem_req    = (state_q == S_FETCH) && !rst;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign op_code     = instr_q[31:26];
  assign pc          = pc_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: each served fetch pushes the expected
// decode view; a negedge monitor pops it when instr_valid rises.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  op_code;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        advance;
  logic        jump;
  logic        branch;
  logic        zero;
  logic [31:0] retired;

  typedef struct packed {
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  logic prev_valid = 1'b0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .op_code     (op_code),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .advance     (advance),
    .Jump        (jump),
    .Branch      (branch),
    .Zero        (zero),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare the held instruction against the scoreboard on each new presentation.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (instr_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_instr: got %h expected none", instr);
        end else begin
          mon_e = sb_q.pop_front();
          check_output("mon_instr", instr, mon_e.instr);
          check_output("mon_op_code", {26'd0, op_code}, {26'd0, mon_e.op});
          check_output("mon_pc", pc, mon_e.pc);
          check_output("mon_pc_plus4", pc_plus4, mon_e.pc_plus4);
        end
      end
      prev_valid = instr_valid;
    end
  end

  // Serve one fetch: wait for the request, return word after the given wait states.
  task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] word,
                                input int waits, input logic poke_adv,
                                input logic [31:0] exp_ret);
    exp_t e;
    int   n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      checks++;
      errors++;
      $display("[TB] FAIL req_timeout: got imem_req=0 expected 1 (addr %h)", addr);
      return;
    end
    check_output("imem_addr", imem_addr, addr);
    e.instr    = word;
    e.op       = word[31:26];
    e.pc       = addr;
    e.pc_plus4 = addr + 32'd4;
    sb_q.push_back(e);
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      advance    = poke_adv;
      jump       = 1'b1;
      branch     = 1'b1;
      zero       = 1'b1;
      @(negedge clk);
      check_output("wait_valid_low", {31'd0, instr_valid}, 32'd0);
      check_output("wait_req_high", {31'd0, imem_req}, 32'd1);
    end
    advance = 1'b0;
    jump    = 1'bx;
    branch  = 1'bx;
    zero    = 1'bx;
    if (poke_adv) begin
      check_output("stray_adv_pc", pc, addr);
      check_output("stray_adv_retired", retired, exp_ret);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
    check_output("valid_after_ready", {31'd0, instr_valid}, 32'd1);
    check_output("req_low_in_hold", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic do_advance(input logic j, input logic b, input logic z,
                            input logic [31:0] exp_pc, input logic [31:0] exp_ret);
    advance = 1'b1;
    jump    = j;
    branch  = b;
    zero    = z;
    @(negedge clk);
    advance = 1'b0;
    jump    = 1'bx;
    branch  = 1'bx;
    zero    = 1'bx;
    check_output("next_pc", pc, exp_pc);
    check_output("retired", retired, exp_ret);
    check_output("valid_cleared", {31'd0, instr_valid}, 32'd0);
    check_output("req_after_advance", {31'd0, imem_req}, 32'd1);
  endtask

  // Stray ready pulses then five idle cycles: the held view must not move.
  task automatic hold_checks(input logic [31:0] word, input logic [31:0] addr);
    for (int i = 0; i < 7; i++) begin
      imem_ready = (i < 2);
      imem_rdata = 32'hDEAD_BEEF;
      advance    = 1'b0;
      @(negedge clk);
      check_output("hold_instr", instr, word);
      check_output("hold_pc", pc, addr);
      check_output("hold_valid", {31'd0, instr_valid}, 32'd1);
      check_output("hold_req", {31'd0, imem_req}, 32'd0);
    end
    imem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    advance    = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    zero       = 1'b0;
    #1;
    check_output("rst_pc", pc, 32'h0);
    check_output("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_output("rst_retired", retired, 32'd0);
    check_output("rst_req", {31'd0, imem_req}, 32'd0);
    check_output("rst_instr", instr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("post_rst_req", {31'd0, imem_req}, 32'd1);
    check_output("post_rst_addr", imem_addr, 32'h0);

    apply_stimulus(32'h0000_0000, 32'h2008_0005, 0, 1'b0, 32'd0);
    do_advance(1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'd1);

    apply_stimulus(32'h0000_0004, 32'h0C00_0004, 0, 1'b0, 32'd1);
    do_advance(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'd2);

    apply_stimulus(32'h0000_0010, 32'h1000_FFFF, 3, 1'b1, 32'd2);
    hold_checks(32'h1000_FFFF, 32'h0000_0010);
    do_advance(1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'd3);

    apply_stimulus(32'h0000_0010, 32'h1000_FFFF, 0, 1'b0, 32'd3);
    do_advance(1'b0, 1'b1, 1'b0, 32'h0000_0014, 32'd4);

    apply_stimulus(32'h0000_0014, 32'h0C00_0010, 1, 1'b0, 32'd4);
    do_advance(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'd5);

    // Reset while the fetch at 0x40 is outstanding; ready during reset is ignored.
    check_output("fetch_0x40_addr", imem_addr, 32'h0000_0040);
    @(negedge clk);
    #2;
    rst        = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'h1234_5678;
    #1;
    check_output("midrst_pc", pc, 32'h0);
    check_output("midrst_req", {31'd0, imem_req}, 32'd0);
    check_output("midrst_retired", retired, 32'd0);
    check_output("midrst_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_output("midrst_instr", instr, 32'd0);
    rst        = 1'b0;
    imem_ready = 1'b0;
    #1;
    check_output("midrst_fresh_req", {31'd0, imem_req}, 32'd1);
    check_output("midrst_fresh_addr", imem_addr, 32'h0);

    apply_stimulus(32'h0000_0000, 32'h1000_FFFE, 0, 1'b0, 32'd0);
    do_advance(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'd1);

    apply_stimulus(32'hFFFF_FFFC, 32'h0000_0000, 0, 1'b0, 32'd1);
    do_advance(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'd2);

    apply_stimulus(32'h0000_0000, 32'h0FFF_FFFF, 0, 1'b0, 32'd2);
    do_advance(1'b1, 1'b1, 1'b1, 32'h0FFF_FFFC, 32'd3);

    apply_stimulus(32'h0FFF_FFFC, 32'h0C00_0002, 0, 1'b0, 32'd3);
    do_advance(1'b1, 1'b0, 1'b0, 32'h1000_0008, 32'd4);

    apply_stimulus(32'h1000_0008, 32'h0C00_0040, 2, 1'b0, 32'd4);
    check_output("jal_pc_plus4", pc_plus4, 32'h1000_000C);
    do_advance(1'b1, 1'bx, 1'bx, 32'h1000_0100, 32'd5);

    apply_stimulus(32'h1000_0100, 32'h2008_0005, 0, 1'b0, 32'd5);
    @(negedge clk);
    check_output("scoreboard_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
